// File: rtl/snake_pkg.sv
// Shared encodings and default geometry for the snake game-logic stage and the VGA tile mapping.
package snake_pkg;

  localparam int unsigned DefGridW  = 10;
  localparam int unsigned DefGridH  = 10;
  localparam int unsigned DefMaxLen = 100;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCalc   = 3'd1,
    StScan   = 3'd2,
    StCommit = 3'd3,
    StDead   = 3'd4
  } state_e;

  // Opposite directions differ only in bit 1.
  function automatic logic [1:0] dir_reverse(input logic [1:0] dir);
    return dir ^ 2'd2;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational head stepper: candidate head position and wall test for one move.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int unsigned COORD_W = 32,
  parameter int unsigned GRID_W  = DefGridW,
  parameter int unsigned GRID_H  = DefGridH
) (
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic [1:0]         dir,
  output logic [COORD_W-1:0] nh_x,
  output logic [COORD_W-1:0] nh_y,
  output logic               wall_hit
);

  localparam logic [COORD_W-1:0] XMax = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] YMax = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] One  = COORD_W'(1);

  // Wall is tested on the unstepped head, so the stepped value never wraps.
  always_comb begin
    nh_x     = head_x;
    nh_y     = head_y;
    wall_hit = 1'b0;
    unique case (dir)
      DIR_UP: begin
        if (head_y == '0) wall_hit = 1'b1;
        else              nh_y     = head_y - One;
      end
      DIR_RIGHT: begin
        if (head_x == XMax) wall_hit = 1'b1;
        else                nh_x     = head_x + One;
      end
      DIR_DOWN: begin
        if (head_y == YMax) wall_hit = 1'b1;
        else                nh_y     = head_y + One;
      end
      DIR_LEFT: begin
        if (head_x == '0) wall_hit = 1'b1;
        else              nh_x     = head_x - One;
      end
      default: wall_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/snake_mover.sv
// Snake body owner: latches direction/grow, scans for self collision one segment per cycle,
// then shifts the whole body in a single commit edge.
module snake_mover
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN   = DefMaxLen,
  parameter int unsigned COORD_W   = 32,
  parameter int unsigned GRID_W    = DefGridW,
  parameter int unsigned GRID_H    = DefGridH,
  parameter int unsigned START_X   = 5,
  parameter int unsigned START_Y   = 5,
  parameter int unsigned START_LEN = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       move_tick,
  input  logic                       dir_valid,
  input  logic [1:0]                 dir_req,
  input  logic                       grow,
  output logic [MAX_LEN*COORD_W-1:0] x_values,
  output logic [MAX_LEN*COORD_W-1:0] y_values,
  output logic [7:0]                 length,
  output logic                       busy,
  output logic                       game_done
);

  localparam int unsigned IdxW = ($clog2(MAX_LEN) > 2) ? $clog2(MAX_LEN) : 2;

  typedef logic [COORD_W-1:0] coord_t;

  coord_t          seg_x_q [MAX_LEN];
  coord_t          seg_y_q [MAX_LEN];
  state_e          state_q, state_d;
  logic [1:0]      cur_dir_q, pend_dir_q;
  logic            grow_pend_q, grow_eff_q, done_q;
  logic [7:0]      len_q;
  logic [IdxW-1:0] idx_q, scan_last_q;
  coord_t          nh_x_q, nh_y_q;

  coord_t          calc_x, calc_y;
  logic            wall_hit;
  logic            grow_eff;
  logic [8:0]      scan_span;
  logic            scan_needed;
  logic            seg_hit;

  snake_next_head #(
    .COORD_W(COORD_W),
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_next_head (
    .head_x  (seg_x_q[0]),
    .head_y  (seg_y_q[0]),
    .dir     (pend_dir_q),
    .nh_x    (calc_x),
    .nh_y    (calc_y),
    .wall_hit(wall_hit)
  );

  // Scan covers idx 2..len+grow_eff-2; without growth the tail vacates and is skipped.
  always_comb begin
    grow_eff    = grow_pend_q && (len_q < 8'(MAX_LEN));
    scan_span   = {1'b0, len_q} + {8'd0, grow_eff};
    scan_needed = (scan_span >= 9'd4);
    seg_hit     = (nh_x_q == seg_x_q[idx_q]) && (nh_y_q == seg_y_q[idx_q]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (move_tick && !done_q) state_d = StCalc;
      end
      StCalc: begin
        if (wall_hit)         state_d = StDead;
        else if (scan_needed) state_d = StScan;
        else                  state_d = StCommit;
      end
      StScan: begin
        if (seg_hit)                    state_d = StDead;
        else if (idx_q == scan_last_q)  state_d = StCommit;
      end
      StCommit: state_d = StIdle;
      StDead:   state_d = StDead;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q == StCalc) || (state_q == StScan) || (state_q == StCommit);
    game_done = done_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < START_LEN) begin
          seg_x_q[i] <= coord_t'(START_X - i);
          seg_y_q[i] <= coord_t'(START_Y);
        end else begin
          seg_x_q[i] <= '0;
          seg_y_q[i] <= '0;
        end
      end
      len_q       <= 8'(START_LEN);
      cur_dir_q   <= DIR_RIGHT;
      pend_dir_q  <= DIR_RIGHT;
      grow_pend_q <= 1'b0;
      grow_eff_q  <= 1'b0;
      done_q      <= 1'b0;
      idx_q       <= '0;
      scan_last_q <= '0;
      nh_x_q      <= '0;
      nh_y_q      <= '0;
    end else begin
      if (dir_valid && (dir_req != dir_reverse(cur_dir_q))) pend_dir_q <= dir_req;

      // A grow pulse landing on the commit edge is kept for the following move.
      if (state_q == StCommit) grow_pend_q <= 1'b0;
      if (grow)                grow_pend_q <= 1'b1;

      if (state_q == StDead) done_q <= 1'b1;

      if (state_q == StCalc) begin
        cur_dir_q   <= pend_dir_q;
        nh_x_q      <= calc_x;
        nh_y_q      <= calc_y;
        grow_eff_q  <= grow_eff;
        scan_last_q <= IdxW'(scan_span - 9'd2);
        idx_q       <= IdxW'(2);
      end

      if (state_q == StScan) idx_q <= idx_q + IdxW'(1);

      if (state_q == StCommit) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_x_q[i] <= seg_x_q[i-1];
          seg_y_q[i] <= seg_y_q[i-1];
        end
        seg_x_q[0] <= nh_x_q;
        seg_y_q[0] <= nh_y_q;
        len_q      <= len_q + 8'(grow_eff_q);
      end
    end
  end

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_pack
    assign x_values[i*COORD_W +: COORD_W] = seg_x_q[i];
    assign y_values[i*COORD_W +: COORD_W] = seg_y_q[i];
  end

  assign length = len_q;

endmodule
